// File: rtl/ok_pipe_pkg.sv
// Shared definitions for the buffered pipe-in endpoint family:
// legal endpoint address window, pack-phase encoding and parameter helpers.
package ok_pipe_pkg;

  localparam logic [7:0] OK_PIPEIN_ADDR_MIN = 8'h80;
  localparam logic [7:0] OK_PIPEIN_ADDR_MAX = 8'h9F;

  typedef enum logic {
    PACK_LO = 1'b0,
    PACK_HI = 1'b1
  } pack_phase_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ok_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and a
// sticky overflow flag; a push into a full FIFO succeeds only alongside a pop.
module ok_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             ti_clock,
  input  logic             ti_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    do_pop  = pop_req && valid;
    do_push = push && (!full || do_pop);
  end

  // Head is shown straight from storage; gated so the output reads zero when empty.
  assign dout = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge ti_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge ti_clock) begin
    if (!ti_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ok_buffered_pipe_in.sv
// Host pipe-in endpoint: accepts 16-bit host writes at EP_ADDR, optionally
// packs pairs into 32-bit words, and buffers them in an FWFT FIFO.
module ok_buffered_pipe_in
  import ok_pipe_pkg::*;
#(
  parameter logic [7:0]  EP_ADDR      = 8'h80,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned READY_THRESH = 256
) (
  input  logic                    ti_clock,
  input  logic                    ti_reset_n,
  input  logic                    ti_write,
  input  logic [7:0]              ti_addr,
  input  logic [15:0]             ti_datain,
  output logic                    ok_ready,
  output logic [DATA_W-1:0]       ep_dataout,
  output logic                    ep_valid,
  input  logic                    ep_read,
  output logic [$clog2(DEPTH):0]  ep_count,
  output logic                    ep_overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (EP_ADDR < OK_PIPEIN_ADDR_MIN || EP_ADDR > OK_PIPEIN_ADDR_MAX) begin : g_bad_addr
    $error("ok_buffered_pipe_in: EP_ADDR out of range 0x80..0x9F");
  end
  if (DATA_W != 16 && DATA_W != 32) begin : g_bad_width
    $error("ok_buffered_pipe_in: DATA_W must be 16 or 32");
  end
  if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 4096) begin : g_bad_depth
    $error("ok_buffered_pipe_in: DEPTH must be a power of 2 in 4..4096");
  end
  if (READY_THRESH < 1 || READY_THRESH > DEPTH) begin : g_bad_thresh
    $error("ok_buffered_pipe_in: READY_THRESH must be in 1..DEPTH");
  end

  logic              addr_hit;
  logic              accept;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic [CW-1:0]     free_cnt;

  assign addr_hit = (ti_addr == EP_ADDR);
  assign accept   = ti_write && addr_hit;

  if (DATA_W == 16) begin : g_narrow
    assign push      = accept;
    assign push_data = ti_datain;
  end else begin : g_wide
    pack_phase_e phase_q;
    pack_phase_e phase_d;
    logic [15:0] lo_q;

    always_ff @(posedge ti_clock) begin
      if (!ti_reset_n) begin
        phase_q <= PACK_LO;
        lo_q    <= '0;
      end else begin
        phase_q <= phase_d;
        if (accept && phase_q == PACK_LO) lo_q <= ti_datain;
      end
    end

    // Phase advances on every accepted word, even if the FIFO later drops the pair.
    always_comb begin
      phase_d = phase_q;
      push    = 1'b0;
      if (accept) begin
        case (phase_q)
          PACK_LO: phase_d = PACK_HI;
          PACK_HI: begin
            phase_d = PACK_LO;
            push    = 1'b1;
          end
          default: phase_d = PACK_LO;
        endcase
      end
    end

    assign push_data = {ti_datain, lo_q};
  end

  ok_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ti_clock   (ti_clock),
    .ti_reset_n (ti_reset_n),
    .push       (push),
    .push_data  (push_data),
    .pop_req    (ep_read),
    .dout       (ep_dataout),
    .valid      (ep_valid),
    .count      (ep_count),
    .overflow   (ep_overflow)
  );

  assign free_cnt = CW'(DEPTH) - ep_count;
  assign ok_ready = addr_hit && (free_cnt >= CW'(READY_THRESH));

endmodule

// File: tb/tb_ok_buffered_pipe_in.sv
// Directed bench for ok_buffered_pipe_in: a 16-bit and a 32-bit packing
// instance, both DEPTH=4 and READY_THRESH=2, on a shared clock and reset.
module tb_ok_buffered_pipe_in;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        wr16, rd16;
  logic [7:0]  addr16;
  logic [15:0] din16;
  logic        rdy16, val16, ovf16;
  logic [15:0] dout16;
  logic [2:0]  cnt16;

  logic        wr32, rd32;
  logic [7:0]  addr32;
  logic [15:0] din32;
  logic        rdy32, val32, ovf32;
  logic [31:0] dout32;
  logic [2:0]  cnt32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ok_buffered_pipe_in #(
    .EP_ADDR      (8'h80),
    .DATA_W       (16),
    .DEPTH        (4),
    .READY_THRESH (2)
  ) u16 (
    .ti_clock   (clk),
    .ti_reset_n (rst_n),
    .ti_write   (wr16),
    .ti_addr    (addr16),
    .ti_datain  (din16),
    .ok_ready   (rdy16),
    .ep_dataout (dout16),
    .ep_valid   (val16),
    .ep_read    (rd16),
    .ep_count   (cnt16),
    .ep_overflow(ovf16)
  );

  ok_buffered_pipe_in #(
    .EP_ADDR      (8'h80),
    .DATA_W       (32),
    .DEPTH        (4),
    .READY_THRESH (2)
  ) u32 (
    .ti_clock   (clk),
    .ti_reset_n (rst_n),
    .ti_write   (wr32),
    .ti_addr    (addr32),
    .ti_datain  (din32),
    .ok_ready   (rdy32),
    .ep_dataout (dout32),
    .ep_valid   (val32),
    .ep_read    (rd32),
    .ep_count   (cnt32),
    .ep_overflow(ovf32)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write16(input logic [15:0] d, input logic [7:0] a);
    wr16 = 1'b1; addr16 = a; din16 = d;
    cyc();
    wr16 = 1'b0; addr16 = 8'h80;
  endtask

  task automatic write32(input logic [15:0] d);
    wr32 = 1'b1; addr32 = 8'h80; din32 = d;
    cyc();
    wr32 = 1'b0;
  endtask

  task automatic pop16();
    rd16 = 1'b1;
    cyc();
    rd16 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr16 = 1'b1; addr16 = 8'h80; din16 = 16'h1234;
    wr32 = 1'b1; addr32 = 8'h80; din32 = 16'h5678;
    rd16 = 1'b1; rd32 = 1'b1;
    do_reset();
    wr16 = 1'b0; wr32 = 1'b0; rd16 = 1'b0; rd32 = 1'b0;
    total++; if (cnt16 !== 3'd0) begin bad++; $display("FAIL reset_cnt16 got=%0d exp=0", cnt16); end
    total++; if (val16 !== 1'b0) begin bad++; $display("FAIL reset_val16 got=%b exp=0", val16); end
    total++; if (dout16 !== 16'h0) begin bad++; $display("FAIL reset_dout16 got=%h exp=0000", dout16); end
    total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL reset_ovf16 got=%b exp=0", ovf16); end
    total++; if (cnt32 !== 3'd0) begin bad++; $display("FAIL reset_cnt32 got=%0d exp=0", cnt32); end
    total++; if (dout32 !== 32'h0) begin bad++; $display("FAIL reset_dout32 got=%h exp=00000000", dout32); end
  endtask

  task automatic test_basic16();
    do_reset();
    write16(16'h1111, 8'h80);
    total++; if (val16 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", val16); end
    total++; if (dout16 !== 16'h1111) begin bad++; $display("FAIL basic_head1 got=%h exp=1111", dout16); end
    write16(16'h2222, 8'h80);
    total++; if (cnt16 !== 3'd2) begin bad++; $display("FAIL basic_cnt2 got=%0d exp=2", cnt16); end
    pop16();
    total++; if (dout16 !== 16'h2222) begin bad++; $display("FAIL basic_head2 got=%h exp=2222", dout16); end
    total++; if (cnt16 !== 3'd1) begin bad++; $display("FAIL basic_cnt1 got=%0d exp=1", cnt16); end
    pop16();
    total++; if (cnt16 !== 3'd0) begin bad++; $display("FAIL basic_cnt0 got=%0d exp=0", cnt16); end
    total++; if (val16 !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", val16); end
    pop16();
    total++; if (cnt16 !== 3'd0) begin bad++; $display("FAIL basic_pop_empty got=%0d exp=0", cnt16); end
  endtask

  task automatic test_pack32();
    do_reset();
    write32(16'hAAAA);
    total++; if (val32 !== 1'b0) begin bad++; $display("FAIL pack_half_valid got=%b exp=0", val32); end
    write32(16'hBBBB);
    total++; if (dout32 !== 32'hBBBBAAAA) begin bad++; $display("FAIL pack_word got=%h exp=BBBBAAAA", dout32); end
    total++; if (cnt32 !== 3'd1) begin bad++; $display("FAIL pack_cnt got=%0d exp=1", cnt32); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) write16(16'(i), 8'h80);
    total++; if (cnt16 !== 3'd4) begin bad++; $display("FAIL ovf_cnt got=%0d exp=4", cnt16); end
    total++; if (ovf16 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf16); end
    for (int i = 1; i <= 4; i++) begin
      total++; if (dout16 !== 16'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, dout16, 16'(i)); end
      pop16();
    end
    total++; if (cnt16 !== 3'd0) begin bad++; $display("FAIL ovf_drain got=%0d exp=0", cnt16); end
    total++; if (ovf16 !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf16); end
    for (int i = 10; i <= 13; i++) write16(16'(i), 8'h80);
    wr16 = 1'b1; addr16 = 8'h80; din16 = 16'd14; rd16 = 1'b1;
    cyc();
    wr16 = 1'b0; rd16 = 1'b0;
    total++; if (cnt16 !== 3'd4) begin bad++; $display("FAIL full_pushpop_cnt got=%0d exp=4", cnt16); end
    total++; if (dout16 !== 16'd11) begin bad++; $display("FAIL full_pushpop_head got=%h exp=000b", dout16); end
    for (int i = 11; i <= 14; i++) begin
      total++; if (dout16 !== 16'(i)) begin bad++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, dout16, 16'(i)); end
      pop16();
    end
  endtask

  task automatic test_ready();
    do_reset();
    addr16 = 8'h81; #1;
    total++; if (rdy16 !== 1'b0) begin bad++; $display("FAIL ready_wrong_addr0 got=%b exp=0", rdy16); end
    addr16 = 8'h80; #1;
    total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL ready_cnt0 got=%b exp=1", rdy16); end
    write16(16'h0001, 8'h80);
    total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL ready_cnt1 got=%b exp=1", rdy16); end
    write16(16'h0002, 8'h80);
    total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL ready_cnt2 got=%b exp=1", rdy16); end
    write16(16'h0003, 8'h80);
    total++; if (rdy16 !== 1'b0) begin bad++; $display("FAIL ready_cnt3 got=%b exp=0", rdy16); end
    addr16 = 8'h81; #1;
    total++; if (rdy16 !== 1'b0) begin bad++; $display("FAIL ready_wrong_addr3 got=%b exp=0", rdy16); end
    addr16 = 8'h80;
  endtask

  task automatic test_reset_half();
    do_reset();
    write32(16'h5555);
    do_reset();
    write32(16'h0001);
    write32(16'h0002);
    total++; if (dout32 !== 32'h00020001) begin bad++; $display("FAIL rst_half_word got=%h exp=00020001", dout32); end
    total++; if (cnt32 !== 3'd1) begin bad++; $display("FAIL rst_half_cnt got=%0d exp=1", cnt32); end
    total++; if (ovf32 !== 1'b0) begin bad++; $display("FAIL rst_half_ovf got=%b exp=0", ovf32); end
  endtask

  task automatic test_wrong_addr();
    do_reset();
    write16(16'hDEAD, 8'h81);
    total++; if (cnt16 !== 3'd0) begin bad++; $display("FAIL wrong_addr_cnt got=%0d exp=0", cnt16); end
    total++; if (val16 !== 1'b0) begin bad++; $display("FAIL wrong_addr_valid got=%b exp=0", val16); end
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    wr16 = 1'b1; addr16 = 8'h80; din16 = 16'h0007; rd16 = 1'b1;
    cyc();
    wr16 = 1'b0; rd16 = 1'b0;
    total++; if (cnt16 !== 3'd1) begin bad++; $display("FAIL pp_empty_cnt got=%0d exp=1", cnt16); end
    total++; if (dout16 !== 16'h0007) begin bad++; $display("FAIL pp_empty_head got=%h exp=0007", dout16); end
  endtask

  initial begin
    rst_n = 1'b1;
    wr16 = 1'b0; rd16 = 1'b0; addr16 = 8'h80; din16 = '0;
    wr32 = 1'b0; rd32 = 1'b0; addr32 = 8'h80; din32 = '0;
    cyc();
    test_reset();
    test_basic16();
    test_pack32();
    test_overflow();
    test_ready();
    test_reset_half();
    test_wrong_addr();
    test_push_pop_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ok_buffered_pipe_in.md
OK_BUFFERED_PIPE_IN -- requirements
Module: ok_buffered_pipe_in

Interface
REQ-001 SHALL have parameter EP_ADDR, default 8'h80: endpoint address; legal range 8'h80..8'h9F.
REQ-002 SHALL have parameter DATA_W, default 16: consumer word width; legal values 16 or 32.
REQ-003 SHALL have parameter DEPTH, default 512: FIFO entries of DATA_W; power of 2, 4..4096.
REQ-004 SHALL have parameter READY_THRESH, default 256: minimum free entries for ok_ready; 1..DEPTH.
REQ-005 SHALL have port ti_clock  in  1  the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port ti_reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port ti_write  in  1  host write strobe.
REQ-008 SHALL have port ti_addr  in  8  host endpoint address.
REQ-009 SHALL have port ti_datain  in  16  host write data.
REQ-010 SHALL have port ok_ready  out  1  host-side space indication.
REQ-011 SHALL have port ep_dataout  out  DATA_W  head-of-FIFO data.
REQ-012 SHALL have port ep_valid  out  1  ep_dataout holds a valid entry.
REQ-013 SHALL have port ep_read  in  1  consumer pop request.
REQ-014 SHALL have port ep_count  out  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have port ep_overflow  out  1  sticky flag, data dropped.

Function
REQ-016 SHALL accept a host word when ti_write=1 and ti_addr=EP_ADDR in the same cycle; other cycles are ignored.
REQ-017 With DATA_W=16, SHALL push each accepted host word as one entry.
REQ-018 With DATA_W=32, SHALL pack two accepted words into one entry, first word in bits [15:0] and second word in [31:16].
REQ-019 With DATA_W=32, SHALL push only on the second word; the pack phase toggles per accepted word regardless of drops.
REQ-020 SHALL present the FIFO first-word-fall-through: an entry pushed at edge N SHALL show ep_valid=1 and ep_dataout valid after edge N.
REQ-021 SHALL pop when ep_read=1 and ep_valid=1; ep_read while ep_valid=0 SHALL be ignored with no state change.
REQ-022 ep_count SHALL increment on push-only, decrement on pop-only, and hold on push+pop or idle; range 0..DEPTH.
REQ-023 Push while full without a same-cycle pop SHALL drop the entry, leave the FIFO unchanged, and set ep_overflow.
REQ-024 Push while full with a same-cycle pop SHALL be accepted, leaving ep_count=DEPTH.
REQ-025 Push and pop while empty SHALL push only, since ep_valid=0.
REQ-026 ep_overflow SHALL stay set until reset.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-028 ok_ready SHALL be combinational: 1 only when ti_addr=EP_ADDR and (DEPTH - ep_count) >= READY_THRESH, otherwise 0.
REQ-029 SHALL emit an elaboration error for an out-of-range EP_ADDR, DATA_W, DEPTH or READY_THRESH.

Reset
REQ-030 SHALL, on a ti_reset_n=0 edge, clear the pointers, set ep_count=0, ep_valid=0, ep_overflow=0, ep_dataout=0 and pack phase to first word.
REQ-031 Reset SHALL take precedence over a same-cycle ti_write or ep_read; a half-packed word SHALL be discarded.
REQ-032 After release, the first accepted host word SHALL be treated as a low half.

Structure
REQ-033 Shared package ok_pipe_pkg SHALL hold OK_PIPEIN_ADDR_MIN=8'h80 and OK_PIPEIN_ADDR_MAX=8'h9F.
REQ-034 Host-side acceptance and width packing SHALL be in ok_buffered_pipe_in.
REQ-035 Storage, pointers, count and FWFT head SHALL be in one sub-module, ok_sync_fifo, parameterised by width and depth.

Verification
REQ-036 DATA_W=16, DEPTH=4: write 0x1111,0x2222 to 0x80 -> ep_valid next cycle, pops return 0x1111 then 0x2222, ep_count 2->0.
REQ-037 DATA_W=32: write 0xAAAA,0xBBBB -> one entry 0xBBBBAAAA; a single word alone -> ep_valid stays 0.
REQ-038 DEPTH=4: write 5 words, no pops -> ep_count=4, ep_overflow=1, pops return the first 4 only; a 5th write with simultaneous pop -> accepted, ep_count=4.
REQ-039 READY_THRESH=2, DEPTH=4, ti_addr=0x80: ok_ready=1 at count 0..2, ok_ready=0 at count 3; ti_addr=0x81 -> ok_ready=0 always.
REQ-040 DATA_W=32: write one word, pulse ti_reset_n=0 one cycle, then write 0x0001,0x0002 -> single entry 0x00020001, ep_overflow=0.
REQ-041 Write to address 0x81 with EP_ADDR=0x80 -> no push, ep_count=0.
